// File: rtl/md_scheduler.sv
// md_scheduler: request queue and dispatcher for the multiply/divide unit.
// Requests {op, rs, rt} are buffered in a DEPTH-entry FIFO and issued strictly
// in order. mult/div ops start the unit and hold dispatch until it reports
// not busy. mthi/mtlo are written straight through. mfhi/mflo are answered
// from the unit's HI/LO on the cycle after dispatch.
module md_scheduler #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        flush,
    output logic        md_start,
    output logic [2:0]  md_op,
    output logic [31:0] md_d1,
    output logic [31:0] md_d2,
    input  logic        md_busy,
    input  logic [31:0] md_hi,
    input  logic [31:0] md_lo,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        idle
);

    // Op encoding shared with the multiply/divide unit.
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MFHI  = 3'd4;
    localparam logic [2:0] OP_MFLO  = 3'd5;
    localparam logic [2:0] OP_MTHI  = 3'd6;
    localparam logic [2:0] OP_MTLO  = 3'd7;

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // IDLE: free to dispatch. WAIT: a mult/div is running in the unit.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // FIFO storage and bookkeeping
    logic [2:0]       r_op_mem [DEPTH];
    logic [31:0]      r_a_mem  [DEPTH];
    logic [31:0]      r_b_mem  [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Read-back path for mfhi/mflo
    logic        r_rd_valid;
    logic [31:0] r_rd_data;

    logic        w_empty;
    logic        w_full;
    logic        w_push;
    logic        w_pop;
    logic [2:0]  w_head_op;
    logic [31:0] w_head_a;
    logic [31:0] w_head_b;
    logic        w_head_muldiv;
    logic        w_head_mt;
    logic        w_head_mf;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == FULL_CNT);
    assign req_ready = !w_full;

    // No bypass: a request is only visible at the head the cycle after it is written.
    assign w_push = req_valid && req_ready && !flush;

    assign w_head_op = r_op_mem[r_rd_ptr];
    assign w_head_a  = r_a_mem[r_rd_ptr];
    assign w_head_b  = r_b_mem[r_rd_ptr];

    assign w_head_muldiv = (w_head_op == OP_MULT) || (w_head_op == OP_MULTU) ||
                           (w_head_op == OP_DIV)  || (w_head_op == OP_DIVU);
    assign w_head_mt     = (w_head_op == OP_MTHI) || (w_head_op == OP_MTLO);
    assign w_head_mf     = (w_head_op == OP_MFHI) || (w_head_op == OP_MFLO);

    // Write incoming requests into the slot at the write pointer.
    // NOTE: the storage array is deliberately left unreset; r_count and the
    // pointers alone say which slots hold live data, so clearing it would be wasted logic.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_op_mem[r_wr_ptr] <= req_op;
            r_a_mem[r_wr_ptr]  <= req_a;
            r_b_mem[r_wr_ptr]  <= req_b;
        end
    end

    // Advance pointers and occupancy; flush discards everything not yet dispatched.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Scheduler state register; reset abandons any op the unit is running.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Dispatch decision, unit drive and next state.
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        md_start    = 1'b0;
        md_op       = OP_MFHI;
        md_d1       = '0;
        md_d2       = '0;

        case (r_state)
            S_IDLE: begin
                if (!w_empty && !md_busy && !flush) begin
                    w_pop = 1'b1;
                    md_op = w_head_op;
                    if (w_head_muldiv) begin
                        md_start    = 1'b1;
                        md_d1       = w_head_a;
                        md_d2       = w_head_b;
                        w_state_nxt = S_WAIT;
                    end else if (w_head_mt) begin
                        md_d1 = w_head_a;
                    end
                end
            end
            S_WAIT: begin
                // The exit cycle itself never dispatches, so an mfhi/mflo
                // queued behind a mult/div sees settled HI/LO.
                if (!md_busy) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Capture HI or LO for a dispatched mfhi/mflo and flag it for one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= w_pop && w_head_mf;
            if (w_pop && w_head_mf) begin
                r_rd_data <= (w_head_op == OP_MFHI) ? md_hi : md_lo;
            end
        end
    end

    // A flush in the return cycle cancels the pending read result.
    assign rd_valid = r_rd_valid && !flush;
    assign rd_data  = r_rd_data;

    assign idle = w_empty && (r_state == S_IDLE) && !md_busy && !r_rd_valid;

endmodule

// File: tb/tb_md_scheduler.sv
// tb_md_scheduler: directed scenarios plus randomized traffic for md_scheduler,
// checked every cycle against a queue-based reference model and a simple
// multiply/divide unit model that reacts to the scheduler's outputs.
module tb_md_scheduler;

    localparam int DEPTH = 2;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        flush;
    logic        md_start;
    logic [2:0]  md_op;
    logic [31:0] md_d1;
    logic [31:0] md_d2;
    logic        md_busy;
    logic [31:0] md_hi;
    logic [31:0] md_lo;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        idle;

    md_scheduler #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .flush     (flush),
        .md_start  (md_start),
        .md_op     (md_op),
        .md_d1     (md_d1),
        .md_d2     (md_d2),
        .md_busy   (md_busy),
        .md_hi     (md_hi),
        .md_lo     (md_lo),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .idle      (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } req_t;

    // Reference model: pending requests in order, plus "a mult/div is running"
    // and "a read result is due next cycle".
    req_t        m_q[$];
    bit          m_wait;
    bit          m_rd_pend;
    logic [31:0] m_rd_data;

    // Multiply/divide unit model
    int busy_cnt;
    int next_lat;
    bit ext_busy;

    int n_cmp;
    int n_bad;
    int n_start;
    int cyc;

    // Outputs sampled mid-cycle by step()
    logic        s_ready, s_start, s_rdv, s_idle, s_busy;
    logic [2:0]  s_op;
    logic [31:0] s_d1, s_d2, s_rdd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic void unit_exec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] hi, output logic [31:0] lo);
        longint          sa, sb, p;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        hi = '0;
        lo = '0;
        case (op)
            3'd0: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            3'd1: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
            3'd2: begin
                if (b == 32'd0) begin hi = a; lo = '1; end
                else begin p = sa / sb; lo = p[31:0]; p = sa % sb; hi = p[31:0]; end
            end
            3'd3: begin
                if (b == 32'd0) begin hi = a; lo = '1; end
                else begin up = ua / ub; lo = up[31:0]; up = ua % ub; hi = up[31:0]; end
            end
            default: ;
        endcase
    endfunction

    // One clock cycle: compare DUT outputs with the model, then advance the
    // model and the unit across the rising edge.
    task automatic step();
        req_t        h;
        bit          disp;
        bit          push;
        bit          mf;
        logic [31:0] nh, nl;
        int          ncnt;

        md_busy = ext_busy || (busy_cnt > 0);
        @(negedge clk);
        cyc++;
        s_ready = req_ready;
        s_start = md_start;
        s_op    = md_op;
        s_d1    = md_d1;
        s_d2    = md_d2;
        s_rdv   = rd_valid;
        s_rdd   = rd_data;
        s_idle  = idle;
        s_busy  = md_busy;

        disp = 1'b0;
        mf   = 1'b0;
        h.op = 3'd0;
        h.a  = '0;
        h.b  = '0;

        if (!reset) begin
            check("rst_ready", 32'(s_ready), 32'd1);
            check("rst_start", 32'(s_start), 32'd0);
            check("rst_md_op", 32'(s_op), 32'd4);
            check("rst_d1", s_d1, 32'd0);
            check("rst_d2", s_d2, 32'd0);
            check("rst_rd_valid", 32'(s_rdv), 32'd0);
            check("rst_rd_data", s_rdd, 32'd0);
            check("rst_idle", 32'(s_idle), 32'(!md_busy));
        end else begin
            if (!m_wait && (m_q.size() != 0) && !md_busy && !flush) begin
                disp = 1'b1;
                h    = m_q[0];
            end
            mf = disp && (h.op == 3'd4 || h.op == 3'd5);
            check("req_ready", 32'(s_ready), 32'(m_q.size() < DEPTH));
            check("md_start", 32'(s_start), 32'(disp && h.op <= 3'd3));
            check("md_op", 32'(s_op), 32'(disp ? h.op : 3'd4));
            if (!mf) check("md_d1", s_d1, disp ? h.a : 32'd0);
            if (!(disp && h.op >= 3'd4)) check("md_d2", s_d2, disp ? h.b : 32'd0);
            check("rd_valid", 32'(s_rdv), 32'(m_rd_pend && !flush));
            check("rd_data", s_rdd, m_rd_data);
            check("idle", 32'(s_idle),
                  32'((m_q.size() == 0) && !m_wait && !md_busy && !m_rd_pend));
        end

        if (!reset) begin
            m_q.delete();
            m_wait    = 1'b0;
            m_rd_pend = 1'b0;
            m_rd_data = '0;
        end else begin
            push = req_valid && (m_q.size() < DEPTH) && !flush;
            if (disp) begin
                void'(m_q.pop_front());
                if (h.op <= 3'd3) m_wait = 1'b1;
            end else if (m_wait && !md_busy) begin
                m_wait = 1'b0;
            end
            m_rd_pend = mf;
            if (mf) m_rd_data = (h.op == 3'd4) ? md_hi : md_lo;
            if (flush) m_q.delete();
            else if (push) m_q.push_back(req_t'{req_op, req_a, req_b});
        end

        nh   = md_hi;
        nl   = md_lo;
        ncnt = busy_cnt;
        if (s_start) begin
            ncnt = next_lat;
            unit_exec(s_op, s_d1, s_d2, nh, nl);
            n_start++;
        end else begin
            if (ncnt > 0) ncnt--;
            if (s_op == 3'd6) nh = s_d1;
            else if (s_op == 3'd7) nl = s_d1;
        end

        @(posedge clk);
        #1;
        busy_cnt = ncnt;
        md_hi    = nh;
        md_lo    = nl;
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        step();
        req_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int k;
        k         = 0;
        req_valid = 1'b0;
        flush     = 1'b0;
        step();
        while (!s_idle && k < 80) begin
            step();
            k++;
        end
        check(tag, 32'(s_idle), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st0, busy_last, mf_cyc, rdv_n;
        logic [31:0] rdv_d;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        flush     = 1'b0;
        md_busy   = 1'b0;
        md_hi     = '0;
        md_lo     = '0;
        busy_cnt  = 0;
        next_lat  = 3;
        ext_busy  = 1'b0;
        n_cmp     = 0;
        n_bad     = 0;
        n_start   = 0;
        cyc       = 0;
        m_wait    = 1'b0;
        m_rd_pend = 1'b0;
        m_rd_data = '0;
        #1;
        reset = 1'b0;

        // Reset state, then idle right after release
        step();
        step();
        reset = 1'b1;
        step();
        check("idle_after_reset", 32'(s_idle), 32'd1);

        // mult 3 * -2 with a 5-cycle unit, then mflo
        next_lat  = 5;
        st0       = n_start;
        busy_last = -1;
        mf_cyc    = -1;
        rdv_n     = 0;
        rdv_d     = '0;
        send(3'd0, 32'd3, 32'hFFFF_FFFE);
        send(3'd5, 32'd0, 32'd0);
        for (int k = 0; k < 20; k++) begin
            step();
            if (s_busy) busy_last = cyc;
            if (s_op == 3'd5 && mf_cyc < 0) mf_cyc = cyc;
            if (s_rdv) begin
                rdv_n++;
                rdv_d = s_rdd;
            end
        end
        check("mult_start_pulses", 32'(n_start - st0), 32'd1);
        check("mflo_after_exit", 32'(mf_cyc - busy_last), 32'd2);
        check("mflo_rd_valid_cycles", 32'(rdv_n), 32'd1);
        check("mflo_rd_data", rdv_d, 32'hFFFF_FFFA);
        drain("drain_mult");

        // Three back-to-back requests while the unit is busy
        ext_busy  = 1'b1;
        req_valid = 1'b1;
        req_op    = 3'd7;
        req_a     = 32'd1;
        req_b     = 32'd0;
        step();
        check("fill_ready_1", 32'(s_ready), 32'd1);
        req_a = 32'd2;
        step();
        check("fill_ready_2", 32'(s_ready), 32'd1);
        req_a = 32'd3;
        step();
        check("full_blocks", 32'(s_ready), 32'd0);
        step();
        check("full_still_blocks", 32'(s_ready), 32'd0);
        ext_busy = 1'b0;
        step();
        check("ready_in_dispatch_cycle", 32'(s_ready), 32'd0);
        check("first_dispatch_op", 32'(s_op), 32'd7);
        check("first_dispatch_d1", s_d1, 32'd1);
        step();
        check("third_accepted", 32'(s_ready), 32'd1);
        req_valid = 1'b0;
        drain("drain_fill");

        // mthi passes straight through for one cycle
        send(3'd6, 32'h1234_5678, 32'd0);
        step();
        check("mthi_op", 32'(s_op), 32'd6);
        check("mthi_d1", s_d1, 32'h1234_5678);
        check("mthi_start", 32'(s_start), 32'd0);
        step();
        check("mthi_stays_idle", 32'(s_idle), 32'd1);
        check("mthi_one_cycle", 32'(s_op), 32'd4);

        // Flush during WAIT with two requests queued
        next_lat = 6;
        send(3'd0, 32'd5, 32'd7);
        send(3'd2, 32'd100, 32'd7);
        send(3'd4, 32'd0, 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        st0   = n_start;
        step();
        check("flush_empties", 32'(s_ready), 32'd1);
        drain("drain_flush");
        check("no_start_after_flush", 32'(n_start - st0), 32'd0);

        // Flush in the cycle after an mfhi dispatch
        send(3'd4, 32'd0, 32'd0);
        step();
        check("mfhi_dispatched", 32'(s_op), 32'd4);
        flush = 1'b1;
        step();
        check("flushed_rd_valid", 32'(s_rdv), 32'd0);
        flush = 1'b0;
        step();
        check("flushed_rd_valid_after", 32'(s_rdv), 32'd0);

        // Reset mid-WAIT acts immediately
        next_lat = 8;
        send(3'd1, 32'd7, 32'd9);
        step();
        step();
        #2;
        reset = 1'b0;
        #1;
        check("async_ready", 32'(req_ready), 32'd1);
        check("async_start", 32'(md_start), 32'd0);
        check("async_md_op", 32'(md_op), 32'd4);
        check("async_d1", md_d1, 32'd0);
        check("async_d2", md_d2, 32'd0);
        check("async_rd_valid", 32'(rd_valid), 32'd0);
        check("async_rd_data", rd_data, 32'd0);
        step();
        reset = 1'b1;
        send(3'd6, 32'hCAFE_0001, 32'd0);
        drain("drain_after_reset");

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            req_valid = ($urandom_range(0, 99) < 55);
            req_op    = 3'($urandom_range(0, 7));
            req_a     = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
            req_b     = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            flush     = ($urandom_range(0, 99) < 4);
            next_lat  = $urandom_range(1, 6);
            step();
        end
        drain("drain_random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/md_scheduler.md
MD_SCHEDULER -- requirements
Module: md_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 2, giving the request queue depth (power of two, 2..8).
REQ-002 SHALL have op encoding: 0 mult, 1 multu, 2 div, 3 divu, 4 mfhi, 5 mflo, 6 mthi, 7 mtlo.
REQ-003 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have ports req_valid in 1, req_ready out 1: pipeline request handshake.
REQ-006 SHALL have ports req_op in 3, req_a in 32, req_b in 32: request op and operands (rs, rt).
REQ-007 SHALL have port flush  in  1  exception/interrupt flush of all not-yet-dispatched work.
REQ-008 SHALL have ports md_start out 1, md_op out 3, md_d1 out 32, md_d2 out 32: drive the multiply/divide unit.
REQ-009 SHALL have ports md_busy in 1, md_hi in 32, md_lo in 32: unit status and HI/LO contents.
REQ-010 SHALL have ports rd_valid out 1, rd_data out 32: mfhi/mflo result return.
REQ-011 SHALL have port idle  out 1  queue empty, state IDLE, md_busy low, no rd_valid pending.

Function
REQ-012 SHALL hold requests in a DEPTH-entry FIFO storing {op, a, b}; req_ready = !full.
REQ-013 SHALL enqueue when req_valid && req_ready && !flush; no bypass, so dispatch occurs no earlier than the cycle after enqueue.
REQ-014 SHALL implement states IDLE and WAIT.
REQ-015 SHALL dispatch the FIFO head only in IDLE with FIFO non-empty, md_busy == 0 and flush == 0; dispatch pops the head in the same cycle.
REQ-016 SHALL, on dispatch of op 0-3: assert md_start = 1 combinationally for that cycle only, drive md_op/md_d1/md_d2 from the head, and go to WAIT.
REQ-017 SHALL, on dispatch of op 6/7: drive md_op/md_d1 from the head with md_start = 0 for that cycle only, and stay in IDLE.
REQ-018 SHALL, on dispatch of op 4/5: register rd_data <= md_hi (op 4) or md_lo (op 5), set rd_valid = 1 for exactly the next cycle, and stay in IDLE.
REQ-019 SHALL drive md_op = 4 (mfhi, a no-op at the unit) and md_d1 = md_d2 = 0 whenever no dispatch occurs.
REQ-020 SHALL leave WAIT for IDLE in the first cycle after md_start with md_busy == 0; no dispatch occurs in that exit cycle.
REQ-021 SHALL, on flush: empty the FIFO (pointers and count to 0), block enqueue and dispatch that cycle, and clear any pending rd_valid; an op already in WAIT completes normally.
REQ-022 SHALL handle dequeue and enqueue in the same cycle with the count unchanged; FIFO pointers wrap modulo DEPTH.
REQ-023 SHALL keep requests in strict FIFO order; an mfhi/mflo is never dispatched while a prior mult/div is in flight.

Reset
REQ-024 SHALL, with reset low, asynchronously force: FIFO empty, state IDLE, req_ready = 1, md_start = 0, md_op = 4, md_d1 = md_d2 = 0, rd_valid = 0, rd_data = 0.
REQ-025 SHALL treat reset asserted mid-WAIT as abandoning the op; after release, dispatch waits only on md_busy.
REQ-026 SHALL have idle = 1 after reset release.

Verification
REQ-027 SHALL cover: mult a=3, b=-2, model busy for 5 cycles, then mflo -> one md_start pulse; mflo dispatched in the cycle after busy falls; rd_valid one cycle with rd_data = md_lo = 0xFFFFFFFA.
REQ-028 SHALL cover: DEPTH=2, three back-to-back requests while md_busy = 1 -> req_ready = 0 after two; the third is accepted only after the first dispatch.
REQ-029 SHALL cover: mthi a=0x12345678 -> md_op = 6, md_d1 = 0x12345678, md_start = 0 for one cycle; state remains IDLE.
REQ-030 SHALL cover: flush during WAIT with two queued requests -> FIFO count 0, no md_start after busy falls, idle = 1 once md_busy = 0.
REQ-031 SHALL cover: flush in the cycle after an mfhi dispatch -> rd_valid stays 0.
REQ-032 SHALL cover: reset low mid-WAIT -> all outputs at REQ-024 values immediately without a clock edge, req_ready = 1.
